// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO management target: oversamples MDC/MDIO in the clk domain, decodes
// read/write frames addressed to PHY_ADDR, serves a 16-bit register file, reports writes.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          NUM_REGS     = 32,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID_HI    = 16'h0022,
  parameter logic [15:0] PHY_ID_LO    = 16'h1620
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic [15:0] status_in,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  // Handshake: wr_valid is a one-clk strobe with no ready; wr_addr/wr_data are valid
  // while wr_valid is high and then hold until the next accepted write.

  logic        mdc_s1, mdc_s2, mdc_s3;
  logic        mdio_s1, mdio_s2;
  logic        rise, fall, bit_in;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [5:0]  pre_cnt, pre_nx;
  logic        op_hi, op_hi_nx;
  logic        is_read, is_read_nx;
  logic        matched, matched_nx;
  logic [4:0]  phyad_sh, phyad_nx;
  logic [4:0]  reg_sh, reg_nx;
  logic [15:0] data_sh, data_nx;
  logic [15:0] rd_data, rd_nx;
  logic        out_nx, oen_nx;
  logic        wr_en;
  logic [4:0]  wr_a;
  logic [15:0] wr_d;

  logic [15:0] regs [NUM_REGS];
  logic [4:0]  reg_addr_nx;
  logic [15:0] rd_mux;

  assign rise   = mdc_s2 & ~mdc_s3;
  assign fall   = ~mdc_s2 & mdc_s3;
  assign bit_in = mdio_s2;
  assign reg_addr_nx = {reg_sh[3:0], bit_in};

  function automatic logic is_mapped(input logic [4:0] a);
    return (32'(a) < NUM_REGS);
  endfunction

  function automatic logic is_writable(input logic [4:0] a);
    return is_mapped(a) && (a != 5'd1) && (a != 5'd2) && (a != 5'd3);
  endfunction

  always_comb begin
    rd_mux = 16'hFFFF;
    if (is_mapped(reg_addr_nx)) begin
      case (reg_addr_nx)
        5'd1:    rd_mux = status_in;
        5'd2:    rd_mux = PHY_ID_HI;
        5'd3:    rd_mux = PHY_ID_LO;
        default: rd_mux = regs[reg_addr_nx[AW-1:0]];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_s1  <= 1'b1;
      mdc_s2  <= 1'b1;
      mdc_s3  <= 1'b1;
      mdio_s1 <= 1'b1;
      mdio_s2 <= 1'b1;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_s3  <= mdc_s2;
      mdio_s1 <= mdio_in;
      mdio_s2 <= mdio_s1;
    end
  end

  // Frame decoder advances one bit per MDC rise; drive values change only on MDC falls.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pre_nx     = pre_cnt;
    op_hi_nx   = op_hi;
    is_read_nx = is_read;
    matched_nx = matched;
    phyad_nx   = phyad_sh;
    reg_nx     = reg_sh;
    data_nx    = data_sh;
    rd_nx      = rd_data;
    out_nx     = mdio_out;
    oen_nx     = mdio_oen;
    wr_en      = 1'b0;
    wr_a       = reg_sh;
    wr_d       = 16'h0000;

    if (rise) begin
      case (state)
        S_IDLE: begin
          if (bit_in) begin
            pre_nx = (pre_cnt == 6'd32) ? 6'd32 : pre_cnt + 6'd1;
          end else begin
            if (32'(pre_cnt) >= PREAMBLE_MIN) state_nx = S_ST;
            pre_nx = 6'd0;
          end
        end
        S_ST: begin
          state_nx = bit_in ? S_OP : S_IDLE;
          cnt_nx   = 5'd0;
        end
        S_OP: begin
          if (cnt == 5'd0) begin
            op_hi_nx = bit_in;
            cnt_nx   = 5'd1;
          end else if (op_hi != bit_in) begin
            is_read_nx = op_hi;
            state_nx   = S_PHYAD;
            cnt_nx     = 5'd0;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_PHYAD: begin
          phyad_nx = {phyad_sh[3:0], bit_in};
          if (cnt == 5'd4) begin
            matched_nx = (phyad_nx == PHY_ADDR);
            state_nx   = S_REGAD;
            cnt_nx     = 5'd0;
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
        S_REGAD: begin
          reg_nx = reg_addr_nx;
          if (cnt == 5'd4) begin
            rd_nx    = rd_mux;
            state_nx = S_TA;
            cnt_nx   = 5'd0;
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
        S_TA: begin
          if (cnt == 5'd1) begin
            state_nx = S_DATA;
            cnt_nx   = 5'd0;
          end else begin
            cnt_nx = 5'd1;
          end
        end
        S_DATA: begin
          data_nx = {data_sh[14:0], bit_in};
          if (cnt == 5'd15) begin
            state_nx = S_IDLE;
            if (!is_read && matched && is_writable(reg_sh)) begin
              wr_en = 1'b1;
              wr_a  = reg_sh;
              wr_d  = data_nx;
            end
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    if (fall) begin
      out_nx = 1'b1;
      oen_nx = 1'b1;
      if (is_read && matched && state == S_TA && cnt == 5'd1) begin
        out_nx = 1'b0;
        oen_nx = 1'b0;
      end else if (is_read && matched && state == S_DATA) begin
        out_nx = rd_data[~cnt[3:0]];
        oen_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      pre_cnt  <= 6'd0;
      op_hi    <= 1'b0;
      is_read  <= 1'b0;
      matched  <= 1'b0;
      phyad_sh <= 5'd0;
      reg_sh   <= 5'd0;
      data_sh  <= 16'h0000;
      rd_data  <= 16'h0000;
      mdio_out <= 1'b1;
      mdio_oen <= 1'b1;
      wr_valid <= 1'b0;
      wr_addr  <= 5'd0;
      wr_data  <= 16'h0000;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pre_cnt  <= pre_nx;
      op_hi    <= op_hi_nx;
      is_read  <= is_read_nx;
      matched  <= matched_nx;
      phyad_sh <= phyad_nx;
      reg_sh   <= reg_nx;
      data_sh  <= data_nx;
      rd_data  <= rd_nx;
      mdio_out <= out_nx;
      mdio_oen <= oen_nx;
      wr_valid <= wr_en;
      if (wr_en) begin
        wr_addr <= wr_a;
        wr_data <= wr_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
    end else if (wr_en) begin
      regs[wr_a[AW-1:0]] <= wr_d;
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: table of MDIO frames with hand-computed results,
// plus a reset-during-read sequence.
module tb_mdio_phy_responder;

  localparam int HALF    = 8;
  localparam int OEN_CLK = 17 * 2 * HALF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        host_drive;
  logic        mdio_out, mdio_oen;
  logic [15:0] status_in;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  wire         mdio_pin = mdio_oen ? host_drive : mdio_out;

  int compared   = 0;
  int mismatched = 0;
  int oen_clks   = 0;
  int wr_pulses  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mdio_phy_responder #(.NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_pin),
    .mdio_out(mdio_out), .mdio_oen(mdio_oen), .status_in(status_in),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always @(negedge clk) begin
    if (!mdio_oen) oen_clks++;
    if (wr_valid) wr_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdc_bit(input logic b, output logic s);
    host_drive = b;
    repeat (HALF) @(negedge clk);
    s = mdio_pin;
    mdc = 1'b1;
    repeat (HALF) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input int stop_at,
                           output logic [15:0] rd, output logic ta2);
    logic s;
    rd  = 16'h0000;
    ta2 = 1'b1;
    mdc_bit(1'b0, s);
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, s);
    mdc_bit(1'b0, s);
    mdc_bit(1'b1, s);
    mdc_bit(op[1], s);
    mdc_bit(op[0], s);
    for (int i = 4; i >= 0; i--) mdc_bit(phy[i], s);
    for (int i = 4; i >= 0; i--) mdc_bit(rg[i], s);
    mdc_bit(1'b1, s);
    mdc_bit((op == 2'b01) ? 1'b0 : 1'b1, ta2);
    for (int i = 0; i < 16; i++) begin
      if (i == stop_at) begin
        host_drive = 1'b1;
        repeat (5) @(negedge clk);
        check("drive_before_reset", {31'd0, mdio_oen}, 32'd0);
        reset = 1'b1;
        #1;
        check("reset_oen", {31'd0, mdio_oen}, 32'd1);
        check("reset_out", {31'd0, mdio_out}, 32'd1);
        check("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("reset_wr_data", {16'd0, wr_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        return;
      end
      mdc_bit((op == 2'b01) ? wd[15-i] : 1'b1, s);
      rd[15-i] = s;
    end
    mdc_bit(1'b1, s);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_ta2;
    int          exp_oen;
    int          exp_wr;
    logic [4:0]  exp_wa;
    logic [15:0] exp_wdat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [15:0] rd;
    logic        ta2;
    int          oen0, wr0;

    vecs[0]  = '{32, 2'b10, 5'd1, 5'd2,  16'h0000, 16'h0022, 1'b0, OEN_CLK, 0, 5'd0,  16'h0000};
    vecs[1]  = '{32, 2'b01, 5'd1, 5'd0,  16'h1140, 16'hFFFF, 1'b0, 0,       1, 5'd0,  16'h1140};
    vecs[2]  = '{32, 2'b10, 5'd1, 5'd0,  16'h0000, 16'h1140, 1'b0, OEN_CLK, 0, 5'd0,  16'h1140};
    vecs[3]  = '{32, 2'b10, 5'd5, 5'd2,  16'h0000, 16'hFFFF, 1'b1, 0,       0, 5'd0,  16'h1140};
    vecs[4]  = '{32, 2'b10, 5'd1, 5'd3,  16'h0000, 16'h1620, 1'b0, OEN_CLK, 0, 5'd0,  16'h1140};
    vecs[5]  = '{31, 2'b10, 5'd1, 5'd2,  16'h0000, 16'hFFFF, 1'b1, 0,       0, 5'd0,  16'h1140};
    vecs[6]  = '{32, 2'b11, 5'd1, 5'd2,  16'h0000, 16'hFFFF, 1'b1, 0,       0, 5'd0,  16'h1140};
    vecs[7]  = '{32, 2'b01, 5'd1, 5'd2,  16'hBEEF, 16'hFFFF, 1'b0, 0,       0, 5'd0,  16'h1140};
    vecs[8]  = '{32, 2'b01, 5'd1, 5'd31, 16'h1234, 16'hFFFF, 1'b0, 0,       0, 5'd0,  16'h1140};
    vecs[9]  = '{32, 2'b10, 5'd1, 5'd2,  16'h0000, 16'h0022, 1'b0, OEN_CLK, 0, 5'd0,  16'h1140};
    vecs[10] = '{32, 2'b10, 5'd1, 5'd31, 16'h0000, 16'hFFFF, 1'b0, OEN_CLK, 0, 5'd0,  16'h1140};
    vecs[11] = '{32, 2'b10, 5'd1, 5'd1,  16'h0000, 16'hA5C3, 1'b0, OEN_CLK, 0, 5'd0,  16'h1140};
    vecs[12] = '{32, 2'b01, 5'd5, 5'd5,  16'hABCD, 16'hFFFF, 1'b0, 0,       0, 5'd0,  16'h1140};
    vecs[13] = '{32, 2'b01, 5'd1, 5'd15, 16'h5A5A, 16'hFFFF, 1'b0, 0,       1, 5'd15, 16'h5A5A};
    vecs[14] = '{32, 2'b10, 5'd1, 5'd15, 16'h0000, 16'h5A5A, 1'b0, OEN_CLK, 0, 5'd15, 16'h5A5A};
    vecs[15] = '{32, 2'b10, 5'd1, 5'd5,  16'h0000, 16'h0000, 1'b0, OEN_CLK, 0, 5'd15, 16'h5A5A};
    vecs[16] = '{32, 2'b01, 5'd1, 5'd1,  16'h7777, 16'hFFFF, 1'b0, 0,       0, 5'd15, 16'h5A5A};

    reset      = 1'b1;
    mdc        = 1'b0;
    host_drive = 1'b1;
    status_in  = 16'hA5C3;
    repeat (4) @(negedge clk);
    check("rst_oen", {31'd0, mdio_oen}, 32'd1);
    check("rst_out", {31'd0, mdio_out}, 32'd1);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 17; v++) begin
      oen0 = oen_clks;
      wr0  = wr_pulses;
      exp_q.push_back(vecs[v].exp_rd);
      run_frame(vecs[v].pre, vecs[v].op, vecs[v].phy, vecs[v].rg, vecs[v].wd, -1, rd, ta2);
      if (vecs[v].op != 2'b01) check($sformatf("v%0d_rd", v), {16'd0, rd}, {16'd0, exp_q.pop_front()});
      else void'(exp_q.pop_front());
      check($sformatf("v%0d_ta2", v), {31'd0, ta2}, {31'd0, vecs[v].exp_ta2});
      check($sformatf("v%0d_oen_clks", v), oen_clks - oen0, vecs[v].exp_oen);
      check($sformatf("v%0d_wr_pulses", v), wr_pulses - wr0, vecs[v].exp_wr);
      check($sformatf("v%0d_wr_addr", v), {27'd0, wr_addr}, {27'd0, vecs[v].exp_wa});
      check($sformatf("v%0d_wr_data", v), {16'd0, wr_data}, {16'd0, vecs[v].exp_wdat});
    end

    // Status is sampled live at address time, so a changed input must show on the next read.
    status_in = 16'h0F0F;
    run_frame(32, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd, ta2);
    check("status_live", {16'd0, rd}, 32'h0000_0F0F);

    // Reset in the middle of a read data phase, then full reads recover.
    run_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, 8, rd, ta2);
    oen0 = oen_clks;
    run_frame(32, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd, ta2);
    check("post_reset_rd2", {16'd0, rd}, 32'h0000_0022);
    check("post_reset_ta2", {31'd0, ta2}, 32'd0);
    check("post_reset_oen", oen_clks - oen0, OEN_CLK);
    run_frame(32, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd, ta2);
    check("post_reset_rd0", {16'd0, rd}, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
